car_lane_scheduler: RTL and testbench

//   Owns and sequences the car X positions consumed by the sprite display stage. Once per frame, on the

---
 rtl/car_lane_scheduler.sv | 123 ++++++++++++
 tb/tb_car_lane_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/car_lane_scheduler.sv
// rtl/car_lane_scheduler.sv - per-lane car X stepping during vertical blanking; optional feature macro CAR_SPEEDUP_EN
module car_lane_scheduler #(
  parameter int NUM_LANES      = 5,
  parameter int H_VISIBLE_AREA = 640,
  parameter int BASE_PERIOD    = 4,
  parameter int INIT_SPACING   = 128
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Frame_Tick,
  input  logic                   i_Pause,
  input  logic [2:0]             i_Level,
  output logic [NUM_LANES*10-1:0] o_Car_X_Positions,
  output logic [NUM_LANES-1:0]   o_Direction,
  output logic                   o_Busy,
  output logic                   o_Update_Done
);

  localparam int DIV_W  = (BASE_PERIOD + NUM_LANES > 2) ? $clog2(BASE_PERIOD + NUM_LANES) : 1;
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [9:0]        X_MAX     = 10'(H_VISIBLE_AREA - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [LANE_W-1:0] lane_q;
  logic [9:0]        x_q   [NUM_LANES];
  logic [DIV_W-1:0]  div_q [NUM_LANES];

  int                period;
  logic [DIV_W-1:0]  period_m1;
  logic              expire;
  logic [9:0]        x_next;

`ifdef CAR_SPEEDUP_EN
  logic [2:0]        level_q;
`else
  logic              unused_level;
  assign unused_level = ^i_Level;
`endif

  // Period of the lane being walked, divider expiry and its wrapped next X (compare before arithmetic)
  always_comb begin
    period = BASE_PERIOD + int'(lane_q);
`ifdef CAR_SPEEDUP_EN
    period = period - int'(level_q);
    if (period < 1) period = 1;
`endif
    period_m1 = DIV_W'(period - 1);
    // A divider left above a freshly shortened period expires immediately
    expire = (div_q[lane_q] >= period_m1);
    if (lane_q[0]) begin
      x_next = (x_q[lane_q] == 10'd0) ? X_MAX : x_q[lane_q] - 10'd1;
    end else begin
      x_next = (x_q[lane_q] == X_MAX) ? 10'd0 : x_q[lane_q] + 10'd1;
    end
  end

  // Frame walk FSM: accept an unpaused tick, step one lane per cycle, pulse done, return to idle
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q       <= S_IDLE;
      lane_q        <= '0;
      o_Busy        <= 1'b0;
      o_Update_Done <= 1'b0;
`ifdef CAR_SPEEDUP_EN
      level_q       <= 3'd0;
`endif
      for (int i = 0; i < NUM_LANES; i++) begin
        x_q[i]   <= 10'((i * INIT_SPACING) % H_VISIBLE_AREA);
        div_q[i] <= '0;
      end
    end else begin
      o_Update_Done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_Frame_Tick && !i_Pause) begin
            state_q <= S_STEP;
            lane_q  <= '0;
            o_Busy  <= 1'b1;
`ifdef CAR_SPEEDUP_EN
            level_q <= i_Level;
`endif
          end
        end
        S_STEP: begin
          if (expire) begin
            div_q[lane_q] <= '0;
            x_q[lane_q]   <= x_next;
          end else begin
            div_q[lane_q] <= div_q[lane_q] + DIV_W'(1);
          end
          if (lane_q == LAST_LANE) begin
            state_q       <= S_DONE;
            o_Busy        <= 1'b0;
            o_Update_Done <= 1'b1;
          end else begin
            lane_q <= lane_q + LANE_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          o_Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Flatten lane positions onto the output bus; direction alternates right/left by lane parity
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_out
    assign o_Car_X_Positions[10*g +: 10] = x_q[g];
    assign o_Direction[g]                = (g % 2 == 1);
  end

endmodule

// File: tb/tb_car_lane_scheduler.sv
// tb/tb_car_lane_scheduler.sv - directed self-checking bench for car_lane_scheduler
module tb_car_lane_scheduler;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        tick  = 1'b0;
  logic        pause = 1'b0;
  logic [2:0]  level = 3'd0;

  logic [49:0] x1;
  logic [4:0]  dir1;
  logic        busy1, done1;
  logic [19:0] x2;
  logic [1:0]  dir2;
  logic        busy2, done2;

  int checks = 0;
  int errors = 0;
  int busy_n, done_n, busy_sum, done_sum;

  always #5 clk = ~clk;

  car_lane_scheduler u_dut (
    .i_Clk             (clk),
    .i_Rst             (rst),
    .i_Frame_Tick      (tick),
    .i_Pause           (pause),
    .i_Level           (level),
    .o_Car_X_Positions (x1),
    .o_Direction       (dir1),
    .o_Busy            (busy1),
    .o_Update_Done     (done1)
  );

  car_lane_scheduler #(.NUM_LANES(2), .INIT_SPACING(0)) u_dut2 (
    .i_Clk             (clk),
    .i_Rst             (rst),
    .i_Frame_Tick      (tick),
    .i_Pause           (pause),
    .i_Level           (level),
    .o_Car_X_Positions (x2),
    .o_Direction       (dir2),
    .o_Busy            (busy2),
    .o_Update_Done     (done2)
  );

  function automatic logic [9:0] lx1(input int i);
    return x1[10*i +: 10];
  endfunction

  function automatic logic [9:0] lx2(input int i);
    return x2[10*i +: 10];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_tick(output int b, output int d);
    b = 0;
    d = 0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (busy1) b++;
      if (done1) d++;
      @(negedge clk);
    end
  endtask

  task automatic fast_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_x0", lx1(0), 0);
    check("rst_x1", lx1(1), 128);
    check("rst_x2", lx1(2), 256);
    check("rst_x3", lx1(3), 384);
    check("rst_x4", lx1(4), 512);
    check("rst_dir", dir1, 5'b01010);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst2_x", x2, 0);
    check("rst2_dir", dir2, 2'b10);

    // tick 1: cycle-accurate busy/done window
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("walk_busy_k%0d", c), busy1, 1);
      check($sformatf("walk_done_k%0d", c), done1, 0);
      @(negedge clk);
    end
    check("walk_busy_k6", busy1, 0);
    check("walk_done_k6", done1, 1);
    @(negedge clk);
    check("walk_done_k7", done1, 0);

    // ticks 2..4
    run_tick(busy_n, done_n);
    check("tick2_busy_cycles", busy_n, 5);
    check("tick2_done_pulses", done_n, 1);
    run_tick(busy_n, done_n);
    run_tick(busy_n, done_n);
    check("t4_lane0", lx1(0), 1);
    check("t4_lane1", lx1(1), 128);

    // tick 5: lane1 period 5 steps left
    run_tick(busy_n, done_n);
    check("t5_lane0", lx1(0), 1);
    check("t5_lane1", lx1(1), 127);
    check("t5_lane2", lx1(2), 256);
    check("t5_lane3", lx1(3), 384);
    check("t5_d2_lane0", lx2(0), 1);
    check("t5_d2_lane1_leftwrap", lx2(1), 639);

    // tick 6 with a second tick two cycles later inside the walk
    done_n = 0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    if (done1) done_n++;
    @(negedge clk);
    tick = 1'b1;
    if (done1) done_n++;
    @(negedge clk);
    tick = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (done1) done_n++;
      @(negedge clk);
    end
    check("double_tick_done", done_n, 1);
    run_tick(busy_n, done_n);
    check("t7_lane0", lx1(0), 1);
    run_tick(busy_n, done_n);
    check("t8_lane0", lx1(0), 2);

    // paused ticks are dropped entirely
    pause = 1'b1;
    busy_sum = 0;
    done_sum = 0;
    for (int t = 0; t < 10; t++) begin
      run_tick(busy_n, done_n);
      busy_sum += busy_n;
      done_sum += done_n;
    end
    pause = 1'b0;
    check("pause_busy", busy_sum, 0);
    check("pause_done", done_sum, 0);
    check("pause_lane0", lx1(0), 2);
    check("pause_lane1", lx1(1), 127);
    run_tick(busy_n, done_n);
    check("t9_lane0", lx1(0), 2);
    run_tick(busy_n, done_n);
    check("t10_lane1", lx1(1), 126);
    check("t10_lane0", lx1(0), 2);

    // reset sampled at edge k+3 of a walk
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy1, 0);
    check("midrst_done", done1, 0);
    check("midrst_lane0", lx1(0), 0);
    check("midrst_lane1", lx1(1), 128);
    done_n = 0;
    for (int c = 0; c < 10; c++) begin
      if (done1) done_n++;
      @(negedge clk);
    end
    check("midrst_no_done", done_n, 0);
    check("midrst_lane4", lx1(4), 512);

    // level 3 only matters with the speedup build
    level = 3'd3;
    run_tick(busy_n, done_n);
`ifdef CAR_SPEEDUP_EN
    check("lvl_t1_lane0", lx1(0), 1);
`else
    check("lvl_t1_lane0", lx1(0), 0);
`endif
    run_tick(busy_n, done_n);
    run_tick(busy_n, done_n);
`ifdef CAR_SPEEDUP_EN
    check("lvl_t3_lane0", lx1(0), 3);
    check("lvl_t3_lane1", lx1(1), 127);
`else
    check("lvl_t3_lane0", lx1(0), 0);
    check("lvl_t3_lane1", lx1(1), 128);
`endif
    level = 3'd0;

    // two-lane instance: right wrap of lane0 through 639
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 2556; t++) fast_tick();
    repeat (5) @(negedge clk);
    check("wrap_pre_lane0", lx2(0), 639);
    for (int t = 0; t < 4; t++) fast_tick();
    repeat (5) @(negedge clk);
    check("wrap_lane0", lx2(0), 0);
    check("wrap_lane1", lx2(1), 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
